// File: rtl/vdp_cpu_port.sv
`default_nettype none
// ============================================================================
//  Module   : vdp_cpu_port
//  Purpose  : Z80-facing front end of the VDP. Decodes data/control port
//             accesses using the TMS9918 two-byte control protocol. Drives
//             VRAM writes and read-ahead on the shared VRAM CPU port. Holds
//             R0-R7 and decodes them into video configuration. Latches the
//             frame interrupt into the status flag and the CPU interrupt line.
//  Revision : 1.0 - initial release
// ============================================================================
module vdp_cpu_port (
    input  logic        cpu_clk,
    input  logic        reset,
    input  logic        cpu_port,
    input  logic        cpu_wr,
    input  logic        cpu_rd,
    input  logic [7:0]  cpu_din,
    output logic [7:0]  cpu_dout,
    output logic        cpu_n_int,
    output logic [13:0] vga_addr,
    output logic [7:0]  vga_din,
    output logic        vga_wr,
    output logic        vga_rd,
    input  logic [7:0]  vga_dout,
    input  logic        n_int,
    output logic [1:0]  mode,
    output logic [13:0] name_table_addr,
    output logic [13:0] color_table_addr,
    output logic [13:0] font_addr,
    output logic [13:0] sprite_attr_addr,
    output logic [13:0] sprite_pattern_table_addr,
    output logic        video_on,
    output logic [3:0]  text_color,
    output logic [3:0]  back_color
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RD_REQ = 2'd1,
        S_RD_CAP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    // Only the register bits that feed a decoded output are stored.
    logic        r_r0_m3;
    logic [6:3]  r_r1;
    logic [3:0]  r_r2;
    logic [7:0]  r_r3;
    logic [2:0]  r_r4;
    logic [6:0]  r_r5;
    logic [2:0]  r_r6;
    logic [7:0]  r_r7;

    logic [13:0] r_ptr;
    logic [7:0]  r_first;
    logic        r_phase;
    logic [7:0]  r_rbuf;
    logic        r_flag;
    logic        r_n_int_d;

    logic        w_ctrl_wr;
    logic        w_data_wr;
    logic        w_data_rd;
    logic        w_stat_rd;
    logic        w_ctrl2;
    logic        w_setup_ptr;
    logic        w_start_pf;
    logic        w_capture;
    logic        w_frame_edge;
    logic [13:0] w_ptr_target;

    assign w_ctrl_wr    = cpu_wr &  cpu_port;
    assign w_data_wr    = cpu_wr & ~cpu_port;
    assign w_data_rd    = cpu_rd & ~cpu_port;
    assign w_stat_rd    = cpu_rd &  cpu_port;
    assign w_ctrl2      = w_ctrl_wr & r_phase;
    assign w_setup_ptr  = w_ctrl2 & ~cpu_din[7];
    // A read-setup (00) control write and a data read both launch a prefetch.
    assign w_start_pf   = w_data_rd | (w_setup_ptr & ~cpu_din[6]);
    assign w_capture    = (r_state == S_RD_CAP);
    assign w_frame_edge = r_n_int_d & ~n_int;
    // A read-setup loads the pointer in the same cycle the prefetch address
    // is launched, so the prefetch must see the new pointer value.
    assign w_ptr_target = w_setup_ptr ? {cpu_din[5:0], r_first} : r_ptr;

    // Prefetch FSM state register.
    always_ff @(posedge cpu_clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // Prefetch FSM next state: request one cycle, capture the next, go idle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (w_start_pf) w_state_next = S_RD_REQ;
            S_RD_REQ: w_state_next = S_RD_CAP;
            S_RD_CAP: w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // Port protocol, register file, pointer, read buffer and VRAM strobes.
    always_ff @(posedge cpu_clk) begin
        if (reset) begin
            r_r0_m3  <= 1'b0;
            r_r1     <= 4'd0;
            r_r2     <= 4'd0;
            r_r3     <= 8'd0;
            r_r4     <= 3'd0;
            r_r5     <= 7'd0;
            r_r6     <= 3'd0;
            r_r7     <= 8'd0;
            r_ptr    <= 14'd0;
            r_first  <= 8'd0;
            r_phase  <= 1'b0;
            r_rbuf   <= 8'd0;
            vga_addr <= 14'd0;
            vga_din  <= 8'd0;
            vga_wr   <= 1'b0;
            vga_rd   <= 1'b0;
        end else begin
            vga_wr <= 1'b0;
            vga_rd <= 1'b0;
            if (w_ctrl_wr && !r_phase) begin
                r_first <= cpu_din;
                r_phase <= 1'b1;
            end
            if (w_ctrl2) begin
                r_phase <= 1'b0;
                if (cpu_din[7]) begin
                    case (cpu_din[2:0])
                        3'd0: r_r0_m3 <= r_first[1];
                        3'd1: r_r1    <= r_first[6:3];
                        3'd2: r_r2    <= r_first[3:0];
                        3'd3: r_r3    <= r_first;
                        3'd4: r_r4    <= r_first[2:0];
                        3'd5: r_r5    <= r_first[6:0];
                        3'd6: r_r6    <= r_first[2:0];
                        3'd7: r_r7    <= r_first;
                        default: ;
                    endcase
                end else begin
                    r_ptr <= w_ptr_target;
                end
            end
            if (w_data_wr) begin
                vga_addr <= r_ptr;
                vga_din  <= cpu_din;
                vga_wr   <= 1'b1;
                r_rbuf   <= cpu_din;
                r_ptr    <= r_ptr + 14'd1;
                r_phase  <= 1'b0;
            end
            if (w_data_rd || w_stat_rd) begin
                r_phase <= 1'b0;
            end
            if (w_start_pf) begin
                vga_addr <= w_ptr_target;
                vga_rd   <= 1'b1;
            end
            if (w_capture) begin
                r_rbuf <= vga_dout;
                r_ptr  <= r_ptr + 14'd1;
            end
        end
    end

    // Frame flag: a new frame edge wins over a clearing status read.
    always_ff @(posedge cpu_clk) begin
        if (reset)             r_flag <= 1'b0;
        else if (w_frame_edge) r_flag <= 1'b1;
        else if (w_stat_rd)    r_flag <= 1'b0;
    end

    // Delayed copy of the frame interrupt for falling-edge detection.
    always_ff @(posedge cpu_clk) begin
        if (reset) r_n_int_d <= 1'b1;
        else       r_n_int_d <= n_int;
    end

    assign cpu_dout  = cpu_port ? {r_flag, 7'b0} : r_rbuf;
    assign cpu_n_int = ~(r_flag & r_r1[5]);

    assign mode = r_r1[4] ? 2'd0 :
                  r_r1[3] ? 2'd3 :
                  r_r0_m3 ? 2'd2 : 2'd1;

    assign name_table_addr           = {r_r2, 10'b0};
    assign color_table_addr          = {r_r3, 6'b0};
    assign font_addr                 = {r_r4, 11'b0};
    assign sprite_attr_addr          = {r_r5, 7'b0};
    assign sprite_pattern_table_addr = {r_r6, 11'b0};
    assign video_on                  = r_r1[6];
    assign text_color                = r_r7[7:4];
    assign back_color                = r_r7[3:0];

endmodule
`default_nettype wire

// File: tb/tb_vdp_cpu_port.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vdp_cpu_port
//  Purpose  : Directed self-checking bench for vdp_cpu_port with a VRAM model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vdp_cpu_port;

    logic        clk      = 1'b0;
    logic        reset    = 1'b1;
    logic        cpu_port = 1'b0;
    logic        cpu_wr   = 1'b0;
    logic        cpu_rd   = 1'b0;
    logic [7:0]  cpu_din  = 8'h00;
    logic        n_int    = 1'b1;
    logic [7:0]  vga_dout = 8'h00;
    logic [7:0]  cpu_dout;
    logic        cpu_n_int;
    logic [13:0] vga_addr;
    logic [7:0]  vga_din;
    logic        vga_wr;
    logic        vga_rd;
    logic [1:0]  mode;
    logic [13:0] name_table_addr;
    logic [13:0] color_table_addr;
    logic [13:0] font_addr;
    logic [13:0] sprite_attr_addr;
    logic [13:0] sprite_pattern_table_addr;
    logic        video_on;
    logic [3:0]  text_color;
    logic [3:0]  back_color;

    int tests_run    = 0;
    int tests_failed = 0;
    int rd_count     = 0;
    int gap          = 100;

    logic [7:0] mem [0:16383];

    vdp_cpu_port dut (
        .cpu_clk                   (clk),
        .reset                     (reset),
        .cpu_port                  (cpu_port),
        .cpu_wr                    (cpu_wr),
        .cpu_rd                    (cpu_rd),
        .cpu_din                   (cpu_din),
        .cpu_dout                  (cpu_dout),
        .cpu_n_int                 (cpu_n_int),
        .vga_addr                  (vga_addr),
        .vga_din                   (vga_din),
        .vga_wr                    (vga_wr),
        .vga_rd                    (vga_rd),
        .vga_dout                  (vga_dout),
        .n_int                     (n_int),
        .mode                      (mode),
        .name_table_addr           (name_table_addr),
        .color_table_addr          (color_table_addr),
        .font_addr                 (font_addr),
        .sprite_attr_addr          (sprite_attr_addr),
        .sprite_pattern_table_addr (sprite_pattern_table_addr),
        .video_on                  (video_on),
        .text_color                (text_color),
        .back_color                (back_color)
    );

    always #5 clk = ~clk;

    // VRAM model: synchronous write, read data valid the cycle after vga_rd.
    always @(posedge clk) begin
        if (vga_wr) mem[vga_addr] <= vga_din;
        if (vga_rd) vga_dout <= mem[vga_addr];
    end

    always @(posedge clk) if (vga_rd) rd_count++;

    // Bench preconditions on strobe spacing and exclusivity.
    always @(posedge clk) begin
        if (reset) begin
            gap = 100;
        end else if (cpu_wr || cpu_rd) begin
            assert (gap >= 4) else $error("strobe spacing below 4 cycles");
            assert (!(cpu_wr && cpu_rd)) else $error("cpu_wr and cpu_rd together");
            gap = 1;
        end else if (gap < 100) begin
            gap++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One-cycle write strobe; returns in the cycle after the strobe edge.
    task automatic wstrobe(input logic port, input logic [7:0] d);
        cpu_port = port;
        cpu_din  = d;
        cpu_wr   = 1'b1;
        tick(1);
        cpu_wr   = 1'b0;
    endtask

    task automatic ctrl(input logic [7:0] d);
        wstrobe(1'b1, d);
        tick(4);
    endtask

    // One-cycle read strobe; v is cpu_dout observed during the strobe cycle.
    task automatic rd(input logic port, output logic [7:0] v);
        cpu_port = port;
        cpu_rd   = 1'b1;
        #1;
        v = cpu_dout;
        @(posedge clk);
        #1;
        cpu_rd   = 1'b0;
    endtask

    task automatic test_reset;
        tests_run++;
        if (mode !== 2'd1 || video_on !== 1'b0 || text_color !== 4'd0 || back_color !== 4'd0) begin
            tests_failed++;
            $display("FAIL reset_cfg: mode=%0d video_on=%b text=%h back=%h, need 1 0 0 0", mode, video_on, text_color, back_color);
        end
        tests_run++;
        if (name_table_addr !== 14'd0 || color_table_addr !== 14'd0 || font_addr !== 14'd0 ||
            sprite_attr_addr !== 14'd0 || sprite_pattern_table_addr !== 14'd0) begin
            tests_failed++;
            $display("FAIL reset_tables: %h %h %h %h %h, need all 0", name_table_addr, color_table_addr,
                     font_addr, sprite_attr_addr, sprite_pattern_table_addr);
        end
        tests_run++;
        if (vga_wr !== 1'b0 || vga_rd !== 1'b0 || vga_addr !== 14'd0 || vga_din !== 8'd0 || cpu_n_int !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_vram: wr=%b rd=%b addr=%h din=%h n_int=%b, need 0 0 0 0 1", vga_wr, vga_rd, vga_addr, vga_din, cpu_n_int);
        end
        cpu_port = 1'b0;
        #1;
        tests_run++;
        if (cpu_dout !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_rbuf: got %h need 00", cpu_dout);
        end
        cpu_port = 1'b1;
        #1;
        tests_run++;
        if (cpu_dout !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_status: got %h need 00", cpu_dout);
        end
    endtask

    task automatic test_reg_write;
        ctrl(8'hE0);
        wstrobe(1'b1, 8'h81);
        tests_run++;
        if (video_on !== 1'b1) begin
            tests_failed++;
            $display("FAIL reg_video_on: got %b need 1", video_on);
        end
        tick(4);
        ctrl(8'h0E);
        ctrl(8'h82);
        tests_run++;
        if (name_table_addr !== 14'h3800) begin
            tests_failed++;
            $display("FAIL reg_name_table: got %h need 3800", name_table_addr);
        end
    endtask

    task automatic test_mode_tables;
        ctrl(8'hF0); ctrl(8'h81);
        tests_run++;
        if (mode !== 2'd0 || video_on !== 1'b1) begin
            tests_failed++;
            $display("FAIL mode_text: mode=%0d video_on=%b need 0 1", mode, video_on);
        end
        ctrl(8'h08); ctrl(8'h81);
        tests_run++;
        if (mode !== 2'd3 || video_on !== 1'b0) begin
            tests_failed++;
            $display("FAIL mode_multicolor: mode=%0d video_on=%b need 3 0", mode, video_on);
        end
        ctrl(8'h00); ctrl(8'h81);
        ctrl(8'h02); ctrl(8'h80);
        tests_run++;
        if (mode !== 2'd2) begin
            tests_failed++;
            $display("FAIL mode_graphics2: got %0d need 2", mode);
        end
        ctrl(8'hFF); ctrl(8'h83);
        ctrl(8'hFF); ctrl(8'h84);
        ctrl(8'hFF); ctrl(8'h85);
        ctrl(8'hFF); ctrl(8'h86);
        tests_run++;
        if (color_table_addr !== 14'h3FC0 || font_addr !== 14'h3800 ||
            sprite_attr_addr !== 14'h3F80 || sprite_pattern_table_addr !== 14'h3800) begin
            tests_failed++;
            $display("FAIL tables: color=%h font=%h sattr=%h spat=%h need 3fc0 3800 3f80 3800",
                     color_table_addr, font_addr, sprite_attr_addr, sprite_pattern_table_addr);
        end
        ctrl(8'h00); ctrl(8'h80);
        tests_run++;
        if (mode !== 2'd1) begin
            tests_failed++;
            $display("FAIL mode_graphics1: got %0d need 1", mode);
        end
    endtask

    task automatic test_write_setup;
        int rd0;
        rd0 = rd_count;
        ctrl(8'h00);
        ctrl(8'h40);
        wstrobe(1'b0, 8'h11);
        tests_run++;
        if (vga_wr !== 1'b1 || vga_addr !== 14'h0000 || vga_din !== 8'h11) begin
            tests_failed++;
            $display("FAIL write_first: wr=%b addr=%h din=%h need 1 0000 11", vga_wr, vga_addr, vga_din);
        end
        tick(1);
        tests_run++;
        if (vga_wr !== 1'b0) begin
            tests_failed++;
            $display("FAIL write_pulse_width: wr=%b need 0", vga_wr);
        end
        tick(3);
        wstrobe(1'b0, 8'h22);
        tests_run++;
        if (vga_wr !== 1'b1 || vga_addr !== 14'h0001 || vga_din !== 8'h22) begin
            tests_failed++;
            $display("FAIL write_second: wr=%b addr=%h din=%h need 1 0001 22", vga_wr, vga_addr, vga_din);
        end
        tick(4);
        tests_run++;
        if (rd_count !== rd0) begin
            tests_failed++;
            $display("FAIL write_no_read: vga_rd count %0d need %0d", rd_count, rd0);
        end
        cpu_port = 1'b0;
        #1;
        tests_run++;
        if (cpu_dout !== 8'h22) begin
            tests_failed++;
            $display("FAIL write_rbuf: got %h need 22", cpu_dout);
        end
    endtask

    task automatic test_read_ahead;
        logic [7:0] v;
        mem[14'h3800] = 8'hA5;
        mem[14'h3801] = 8'h5A;
        mem[14'h3802] = 8'hC3;
        ctrl(8'h00);
        wstrobe(1'b1, 8'h38);
        tests_run++;
        if (vga_rd !== 1'b1 || vga_addr !== 14'h3800) begin
            tests_failed++;
            $display("FAIL prefetch_setup: rd=%b addr=%h need 1 3800", vga_rd, vga_addr);
        end
        tick(4);
        rd(1'b0, v);
        tests_run++;
        if (v !== 8'hA5) begin
            tests_failed++;
            $display("FAIL read_first: got %h need a5", v);
        end
        tests_run++;
        if (vga_rd !== 1'b1 || vga_addr !== 14'h3801) begin
            tests_failed++;
            $display("FAIL prefetch_next: rd=%b addr=%h need 1 3801", vga_rd, vga_addr);
        end
        tick(4);
        rd(1'b0, v);
        tests_run++;
        if (v !== 8'h5A || vga_addr !== 14'h3802) begin
            tests_failed++;
            $display("FAIL read_second: data=%h addr=%h need 5a 3802", v, vga_addr);
        end
        tick(4);
    endtask

    task automatic test_wrap;
        ctrl(8'hFF);
        ctrl(8'h7F);
        wstrobe(1'b0, 8'h01);
        tests_run++;
        if (vga_wr !== 1'b1 || vga_addr !== 14'h3FFF || vga_din !== 8'h01) begin
            tests_failed++;
            $display("FAIL wrap_top: wr=%b addr=%h din=%h need 1 3fff 01", vga_wr, vga_addr, vga_din);
        end
        tick(4);
        wstrobe(1'b0, 8'h02);
        tests_run++;
        if (vga_wr !== 1'b1 || vga_addr !== 14'h0000 || vga_din !== 8'h02) begin
            tests_failed++;
            $display("FAIL wrap_zero: wr=%b addr=%h din=%h need 1 0000 02", vga_wr, vga_addr, vga_din);
        end
        tick(4);
    endtask

    task automatic test_interrupt;
        logic [7:0] v;
        ctrl(8'h00); ctrl(8'h81);
        n_int = 1'b0; tick(1); n_int = 1'b1; tick(3);
        cpu_port = 1'b1;
        #1;
        tests_run++;
        if (cpu_n_int !== 1'b1 || cpu_dout !== 8'h80) begin
            tests_failed++;
            $display("FAIL int_masked: n_int=%b status=%h need 1 80", cpu_n_int, cpu_dout);
        end
        ctrl(8'h20);
        wstrobe(1'b1, 8'h81);
        tests_run++;
        if (cpu_n_int !== 1'b0) begin
            tests_failed++;
            $display("FAIL int_enable_late: n_int=%b need 0", cpu_n_int);
        end
        tick(4);
        rd(1'b1, v);
        tests_run++;
        if (v !== 8'h80 || cpu_n_int !== 1'b1) begin
            tests_failed++;
            $display("FAIL status_clear: status=%h n_int=%b need 80 1", v, cpu_n_int);
        end
        tick(4);
        rd(1'b1, v);
        tests_run++;
        if (v !== 8'h00) begin
            tests_failed++;
            $display("FAIL status_second: got %h need 00", v);
        end
        tick(4);
        n_int = 1'b0; tick(1); n_int = 1'b1; tick(1);
        tests_run++;
        if (cpu_n_int !== 1'b0) begin
            tests_failed++;
            $display("FAIL int_assert: n_int=%b need 0", cpu_n_int);
        end
        tick(3);
        rd(1'b1, v);
        tick(4);
        cpu_port = 1'b1;
        cpu_rd   = 1'b1;
        n_int    = 1'b0;
        #1;
        v = cpu_dout;
        tick(1);
        cpu_rd = 1'b0;
        n_int  = 1'b1;
        tests_run++;
        if (v !== 8'h00 || cpu_dout !== 8'h80 || cpu_n_int !== 1'b0) begin
            tests_failed++;
            $display("FAIL edge_vs_read: read=%h status_after=%h n_int=%b need 00 80 0", v, cpu_dout, cpu_n_int);
        end
        tick(4);
        rd(1'b1, v);
        tick(4);
    endtask

    task automatic test_phase_reset;
        logic [7:0] v;
        ctrl(8'h99);
        rd(1'b1, v);
        tick(4);
        ctrl(8'h05);
        ctrl(8'h87);
        tests_run++;
        if (text_color !== 4'h0 || back_color !== 4'h5) begin
            tests_failed++;
            $display("FAIL phase_reset: text=%h back=%h need 0 5", text_color, back_color);
        end
    endtask

    task automatic test_reset_mid_prefetch;
        ctrl(8'h00);
        ctrl(8'h40);
        wstrobe(1'b0, 8'h77);
        tick(4);
        ctrl(8'h00);
        wstrobe(1'b1, 8'h38);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(4);
        cpu_port = 1'b0;
        #1;
        tests_run++;
        if (cpu_dout !== 8'h00 || vga_rd !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_abort: rbuf=%h rd=%b need 00 0", cpu_dout, vga_rd);
        end
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
        tick(3);
        reset = 1'b0;
        test_reset();
        test_reg_write();
        test_mode_tables();
        test_write_setup();
        test_read_ahead();
        test_wrap();
        test_interrupt();
        test_phase_reset();
        test_reset_mid_prefetch();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
